// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - four-digit multiplexed 7-segment scan controller
//
// Captures host digit writes (I/O offsets 0x0E/0x0F) into a 4-entry buffer and
// time-multiplexes the entries onto shared active-low segment lines. Each digit
// slot begins with a short all-off gap so a segment pattern never bleeds into
// the neighbouring digit.
//
// Ports:
//   Mclk      in   system clock, rising edge
//   Reset     in   asynchronous active-high reset
//   DispEn    in   1 = scan, 0 = dark (counters held at zero, writes still taken)
//   SegWrStb  in   one-cycle host write strobe
//   x7SegSel  in   [1:0] digit, [2] out-of-range (write dropped), [3] raw, [4] blink
//   x7SegVal  in   hex nibble + dp, or raw g..a + dp
//   SegOutN   out  active-low segments, [6:0] = g..a, [7] = dp
//   DigEnN    out  active-low digit enables, one-hot or all ones
//   FrameTick out  one-cycle pulse after the last cycle of the digit-3 slot

module seg7_scan_ctrl #(
    parameter int SCAN_DIV  = 1024,
    parameter int BLANK_CYC = 4,
    parameter int BLINK_DIV = 256
) (
    input  logic       Mclk,
    input  logic       Reset,
    input  logic       DispEn,
    input  logic       SegWrStb,
    input  logic [4:0] x7SegSel,
    input  logic [7:0] x7SegVal,
    output logic [7:0] SegOutN,
    output logic [3:0] DigEnN,
    output logic       FrameTick
);

    localparam logic [15:0] CNT_LAST   = 16'(SCAN_DIV - 1);
    localparam logic [15:0] BLANK_END  = 16'(BLANK_CYC);
    localparam logic [15:0] FRAME_LAST = 16'(BLINK_DIV - 1);

    // Digit buffer
    logic [7:0] r_val [4];
    logic [3:0] r_raw;
    logic [3:0] r_blink;

    // Scan state
    logic [15:0] r_cnt;
    logic [1:0]  r_dig;
    logic [15:0] r_frame;
    logic        r_blink_ph;

    // Registered outputs
    logic [7:0] r_seg_n;
    logic [3:0] r_dig_n;
    logic       r_tick;

    logic       w_slot_end;
    logic       w_frame_end;
    logic       w_drive;
    logic [7:0] w_cur_val;
    logic [7:0] w_seg_on;
    logic       w_blanked;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    assign w_slot_end  = (r_cnt == CNT_LAST);
    assign w_frame_end = w_slot_end && (r_dig == 2'd3);
    assign w_drive     = (r_cnt >= BLANK_END);
    assign w_cur_val   = r_val[r_dig];
    assign w_seg_on    = r_raw[r_dig] ? w_cur_val : {w_cur_val[7], hex7(w_cur_val[3:0])};
    // A blinking digit keeps its enable during the off phase; only segments go dark.
    assign w_blanked   = r_blink[r_dig] && r_blink_ph;

    // Host writes land regardless of DispEn; index 4..7 is silently dropped.
    always_ff @(posedge Mclk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < 4; i++) begin
                r_val[i] <= 8'h00;
            end
            r_raw   <= 4'h0;
            r_blink <= 4'h0;
        end else if (SegWrStb && !x7SegSel[2]) begin
            r_val[x7SegSel[1:0]]   <= x7SegVal;
            r_raw[x7SegSel[1:0]]   <= x7SegSel[3];
            r_blink[x7SegSel[1:0]] <= x7SegSel[4];
        end
    end

    // Slot / digit / frame / blink-phase counters; held at zero while dark so
    // re-enable always restarts at digit 0 in its blank gap.
    always_ff @(posedge Mclk or posedge Reset) begin
        if (Reset) begin
            r_cnt      <= 16'd0;
            r_dig      <= 2'd0;
            r_frame    <= 16'd0;
            r_blink_ph <= 1'b0;
        end else if (!DispEn) begin
            r_cnt      <= 16'd0;
            r_dig      <= 2'd0;
            r_frame    <= 16'd0;
            r_blink_ph <= 1'b0;
        end else begin
            if (w_slot_end) begin
                r_cnt <= 16'd0;
                r_dig <= r_dig + 2'd1;
            end else begin
                r_cnt <= r_cnt + 16'd1;
            end
            if (w_frame_end) begin
                if (r_frame == FRAME_LAST) begin
                    r_frame    <= 16'd0;
                    r_blink_ph <= ~r_blink_ph;
                end else begin
                    r_frame <= r_frame + 16'd1;
                end
            end
        end
    end

    // Outputs are computed from the pre-edge scan state, so a buffer write in
    // the middle of a drive phase shows up one cycle later with no gap.
    always_ff @(posedge Mclk or posedge Reset) begin
        if (Reset) begin
            r_dig_n <= 4'hF;
            r_seg_n <= 8'hFF;
            r_tick  <= 1'b0;
        end else begin
            r_tick <= DispEn && w_frame_end;
            if (!DispEn || !w_drive) begin
                r_dig_n <= 4'hF;
                r_seg_n <= 8'hFF;
            end else begin
                r_dig_n <= ~(4'b0001 << r_dig);
                r_seg_n <= w_blanked ? 8'hFF : ~w_seg_on;
            end
        end
    end

    assign SegOutN   = r_seg_n;
    assign DigEnN    = r_dig_n;
    assign FrameTick = r_tick;

endmodule
